// File: rtl/lbm_cache_pkg.sv
// Shared constants and types for the LBM chunk cache sequencer.
// Lane bit 0 is the null (rest) direction; the rest run clockwise from north.
package lbm_cache_pkg;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_CHUNK_WORDS = 4096;
  localparam int DEF_LANES       = 9;

  localparam int LANE_NULL = 0;
  localparam int LANE_N    = 1;
  localparam int LANE_NE   = 2;
  localparam int LANE_E    = 3;
  localparam int LANE_SE   = 4;
  localparam int LANE_S    = 5;
  localparam int LANE_SW   = 6;
  localparam int LANE_W    = 7;
  localparam int LANE_NW   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_e;

  // DRAIN sub-phases: address presented, BRAM data valid, stream beat offered.
  typedef enum logic [1:0] {
    DR_ADDR  = 2'd0,
    DR_DATA  = 2'd1,
    DR_VALID = 2'd2
  } drain_phase_e;

endpackage

// File: rtl/chunk_addr_counter.sv
// Word counter shared by the load and drain phases of chunk_sequencer.
// One bit wider than the BRAM address so a full chunk count never wraps.
module chunk_addr_counter #(
  parameter int ADDR_W      = 12,
  parameter int CHUNK_WORDS = 4096
) (
  input  logic              m00_axis_aclk,
  input  logic              m00_axis_areset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W:0]   count,
  output logic              terminal
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(CHUNK_WORDS - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/chunk_sequencer.sv
// Loads one chunk from the inbound stream into BRAM, hands BRAM to the solver,
// then drains it to the outbound stream. Drain is built only with CHUNK_SEQ_DRAIN_EN.
//
// Stream handshakes (s_axis and m_axis): a beat transfers on a rising edge where
// tvalid and tready are both 1; once m_axis_tvalid rises, m_axis_tdata/tlast hold
// until that transfer, and tvalid never depends combinationally on tready.
module chunk_sequencer
  import lbm_cache_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int CHUNK_WORDS = DEF_CHUNK_WORDS,
  parameter int LANES       = DEF_LANES
) (
  input  logic              m00_axis_aclk,
  input  logic              m00_axis_areset,
  input  logic              start,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [LANES-1:0]  s_axis_tdata,
  output logic              chunk_transfer_ready,
  output logic              chunk_compute_ready,
  output logic [ADDR_W-1:0] DDR_addr,
  output logic [LANES-1:0]  cache_in_data,
  input  logic              compute_done,
  output logic              chunk_drain_active,
  input  logic [LANES-1:0]  cache_out_data,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [LANES-1:0]  m_axis_tdata,
  output logic              busy,
  output logic              done,
  output logic              tlast_err,
  output seq_state_e        fsm_state
);

  seq_state_e        state_q, state_d;
  logic              cnt_clear, cnt_inc;
  logic [ADDR_W:0]   cnt;
  logic              cnt_term;
  logic              beat;
  logic              xfer_stb_q;
  logic [ADDR_W-1:0] ddr_addr_q;
  logic [LANES-1:0]  cache_in_q;
  logic              tlast_err_q;

  chunk_addr_counter #(
    .ADDR_W      (ADDR_W),
    .CHUNK_WORDS (CHUNK_WORDS)
  ) u_cnt (
    .m00_axis_aclk   (m00_axis_aclk),
    .m00_axis_areset (m00_axis_areset),
    .clear           (cnt_clear),
    .inc             (cnt_inc),
    .count           (cnt),
    .terminal        (cnt_term)
  );

  assign s_axis_tready = (state_q == ST_LOAD);
  assign beat          = s_axis_tvalid & s_axis_tready;

  // The final load strobe lands in the first COMPUTE cycle; the solver only
  // gets the BRAM ports once that write has been issued.
  assign chunk_compute_ready  = (state_q == ST_COMPUTE) & ~xfer_stb_q;
  assign chunk_transfer_ready = xfer_stb_q;
  assign DDR_addr             = ddr_addr_q;
  assign cache_in_data        = cache_in_q;
  assign tlast_err            = tlast_err_q;
  assign busy                 = (state_q != ST_IDLE);
  assign done                 = (state_q == ST_DONE);
  assign fsm_state            = state_q;

`ifdef CHUNK_SEQ_DRAIN_EN
  drain_phase_e      phase_q, phase_d;
  logic              m_tvalid_q, m_tlast_q;
  logic [LANES-1:0]  m_tdata_q;
  logic              m_hs;
  logic [ADDR_W-1:0] next_addr;

  assign m_hs               = m_tvalid_q & m_axis_tready;
  assign next_addr          = cnt[ADDR_W-1:0] + ADDR_W'(1);
  assign chunk_drain_active = (state_q == ST_DRAIN);
  assign m_axis_tvalid      = m_tvalid_q;
  assign m_axis_tlast       = m_tlast_q;
  assign m_axis_tdata       = m_tdata_q;
`else
  logic unused_drain_inputs;

  assign unused_drain_inputs = ^{cache_out_data, m_axis_tready};
  assign chunk_drain_active  = 1'b0;
  assign m_axis_tvalid       = 1'b0;
  assign m_axis_tlast        = 1'b0;
  assign m_axis_tdata        = '0;
`endif

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q <= ST_IDLE;
`ifdef CHUNK_SEQ_DRAIN_EN
      phase_q <= DR_ADDR;
`endif
    end else begin
      state_q <= state_d;
`ifdef CHUNK_SEQ_DRAIN_EN
      phase_q <= phase_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
`ifdef CHUNK_SEQ_DRAIN_EN
    phase_d   = phase_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          cnt_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          cnt_inc = 1'b1;
          if (cnt_term) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (compute_done && chunk_compute_ready) begin
`ifdef CHUNK_SEQ_DRAIN_EN
          state_d   = ST_DRAIN;
          cnt_clear = 1'b1;
          phase_d   = DR_ADDR;
`else
          state_d   = ST_DONE;
`endif
        end
      end
`ifdef CHUNK_SEQ_DRAIN_EN
      ST_DRAIN: begin
        case (phase_q)
          DR_ADDR: phase_d = DR_DATA;
          DR_DATA: begin
            phase_d = DR_VALID;
            if (!cnt_term) cnt_inc = 1'b1;
          end
          DR_VALID: begin
            if (m_hs) begin
              if (m_tlast_q) state_d = ST_DONE;
              else           phase_d = DR_DATA;
            end
          end
          default: phase_d = DR_ADDR;
        endcase
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      xfer_stb_q  <= 1'b0;
      ddr_addr_q  <= '0;
      cache_in_q  <= '0;
      tlast_err_q <= 1'b0;
    end else begin
      xfer_stb_q <= beat;
      if (beat) begin
        ddr_addr_q <= cnt[ADDR_W-1:0];
        cache_in_q <= s_axis_tdata;
        if (s_axis_tlast != cnt_term) tlast_err_q <= 1'b1;
      end
`ifdef CHUNK_SEQ_DRAIN_EN
      if (state_q == ST_COMPUTE && state_d == ST_DRAIN) ddr_addr_q <= '0;
      // Next read address goes out with the beat, so BRAM data is ready by handshake+1.
      if (state_q == ST_DRAIN && phase_q == DR_DATA && !cnt_term) ddr_addr_q <= next_addr;
`endif
    end
  end

`ifdef CHUNK_SEQ_DRAIN_EN
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else if (state_q == ST_DRAIN) begin
      if (phase_q == DR_DATA) begin
        m_tdata_q  <= cache_out_data;
        m_tvalid_q <= 1'b1;
        m_tlast_q  <= cnt_term;
      end else if (phase_q == DR_VALID && m_hs) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_chunk_sequencer.sv
// Directed bench for chunk_sequencer with CHUNK_WORDS=4: per-cycle vector table
// for load/compute/reset behaviour, plus hand sequences for drain or done.
module tb_chunk_sequencer;
  import lbm_cache_pkg::*;

  localparam int AW = 12;
  localparam int CW = 4;
  localparam int LN = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [LN-1:0] s_tdata = '0;
  logic          xfer, cready;
  logic [AW-1:0] ddr_addr;
  logic [LN-1:0] cin;
  logic          cdone = 1'b0;
  logic          drain_act;
  logic [LN-1:0] cout;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic [LN-1:0] m_tdata;
  logic          busy, done, terr;
  seq_state_e    fsm_state;

  int n_vec = 0;
  int n_bad = 0;
  int overlap_cnt = 0;
  int tvalid_cnt = 0;
  int drain_cnt = 0;

  logic [LN-1:0] bram [4];
  logic [LN-1:0] exp_q [$];

  chunk_sequencer #(.ADDR_W(AW), .CHUNK_WORDS(CW), .LANES(LN)) dut (
    .m00_axis_aclk        (clk),
    .m00_axis_areset      (rst),
    .start                (start),
    .s_axis_tvalid        (s_tvalid),
    .s_axis_tready        (s_tready),
    .s_axis_tlast         (s_tlast),
    .s_axis_tdata         (s_tdata),
    .chunk_transfer_ready (xfer),
    .chunk_compute_ready  (cready),
    .DDR_addr             (ddr_addr),
    .cache_in_data        (cin),
    .compute_done         (cdone),
    .chunk_drain_active   (drain_act),
    .cache_out_data       (cout),
    .m_axis_tvalid        (m_tvalid),
    .m_axis_tready        (m_tready),
    .m_axis_tlast         (m_tlast),
    .m_axis_tdata         (m_tdata),
    .busy                 (busy),
    .done                 (done),
    .tlast_err            (terr),
    .fsm_state            (fsm_state)
  );

  // ---- clock / reset-free BRAM model ----
  always #5 clk = ~clk;

  always @(posedge clk) cout <= bram[ddr_addr[1:0]];

  always @(negedge clk) begin
    if (xfer && cready) overlap_cnt++;
    if (m_tvalid) tvalid_cnt++;
    if (drain_act) drain_cnt++;
  end

  // ---- vector table ----
  typedef struct packed {
    logic          rst, start, tv;
    logic [LN-1:0] td;
    logic          tl, cd;
    logic [2:0]    st;
    logic          xfer;
    logic [AW-1:0] addr;
    logic [LN-1:0] cin;
    logic          err;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t mk(input logic r, input logic s, input logic tv, input logic [LN-1:0] td,
                              input logic tl, input logic cd, input logic [2:0] st, input logic x,
                              input logic [AW-1:0] a, input logic [LN-1:0] c, input logic e);
    vec_t v;
    v.rst = r; v.start = s; v.tv = tv; v.td = td; v.tl = tl; v.cd = cd;
    v.st = st; v.xfer = x; v.addr = a; v.cin = c; v.err = e;
    return v;
  endfunction

  // ---- scoreboard helpers ----
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    logic [29:0] act, exp;
    logic e_tready, e_cready, e_busy, e_done;
    v = vecs[i];
    rst = v.rst; start = v.start; s_tvalid = v.tv; s_tdata = v.td; s_tlast = v.tl; cdone = v.cd;
    tick();
    e_tready = (v.st == ST_LOAD);
    e_cready = (v.st == ST_COMPUTE) && !v.xfer;
    e_busy   = (v.st != ST_IDLE);
    e_done   = (v.st == ST_DONE);
    exp = {v.st, v.xfer, v.addr, v.cin, e_tready, e_cready, e_busy, e_done, v.err};
    act = {fsm_state, xfer, ddr_addr, cin, s_tready, cready, busy, done, terr};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d: got st=%0d xfer=%b addr=%0h cin=%0h rdy=%b crdy=%b busy=%b done=%b err=%b, expected st=%0d xfer=%b addr=%0h cin=%0h rdy=%b crdy=%b busy=%b done=%b err=%b",
               i, fsm_state, xfer, ddr_addr, cin, s_tready, cready, busy, done, terr,
               v.st, v.xfer, v.addr, v.cin, e_tready, e_cready, e_busy, e_done, v.err);
    end
    rst = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; cdone = 1'b0;
  endtask

  initial begin
    bram[0] = 9'h0AA; bram[1] = 9'h155; bram[2] = 9'h003; bram[3] = 9'h100;

    //           rst start tv  td      tl cd  state       xfer addr cin     err
    vecs[0]  = mk(1, 0, 0, 9'h000, 0, 0, ST_IDLE,    0, 0, 9'h000, 0);
    vecs[1]  = mk(0, 1, 0, 9'h000, 0, 0, ST_LOAD,    0, 0, 9'h000, 0);
    vecs[2]  = mk(0, 0, 1, 9'h001, 0, 0, ST_LOAD,    1, 0, 9'h001, 0);
    vecs[3]  = mk(0, 0, 1, 9'h002, 0, 0, ST_LOAD,    1, 1, 9'h002, 0);
    vecs[4]  = mk(0, 0, 1, 9'h004, 0, 0, ST_LOAD,    1, 2, 9'h004, 0);
    vecs[5]  = mk(0, 0, 1, 9'h1FF, 1, 0, ST_COMPUTE, 1, 3, 9'h1FF, 0);
    vecs[6]  = mk(0, 0, 0, 9'h000, 0, 0, ST_COMPUTE, 0, 3, 9'h1FF, 0);
    vecs[7]  = mk(0, 1, 0, 9'h000, 0, 0, ST_COMPUTE, 0, 3, 9'h1FF, 0);
    vecs[8]  = mk(1, 0, 0, 9'h000, 0, 0, ST_IDLE,    0, 0, 9'h000, 0);
    vecs[9]  = mk(0, 1, 0, 9'h000, 0, 0, ST_LOAD,    0, 0, 9'h000, 0);
    vecs[10] = mk(0, 0, 0, 9'h000, 0, 1, ST_LOAD,    0, 0, 9'h000, 0);
    vecs[11] = mk(0, 0, 1, 9'h0AB, 0, 0, ST_LOAD,    1, 0, 9'h0AB, 0);
    vecs[12] = mk(0, 0, 1, 9'h0CD, 1, 0, ST_LOAD,    1, 1, 9'h0CD, 1);
    vecs[13] = mk(0, 0, 0, 9'h000, 0, 0, ST_LOAD,    0, 1, 9'h0CD, 1);
    vecs[14] = mk(0, 0, 1, 9'h0EF, 0, 0, ST_LOAD,    1, 2, 9'h0EF, 1);
    vecs[15] = mk(0, 0, 1, 9'h012, 0, 0, ST_COMPUTE, 1, 3, 9'h012, 1);
    vecs[16] = mk(0, 0, 0, 9'h000, 0, 0, ST_COMPUTE, 0, 3, 9'h012, 1);
    vecs[17] = mk(1, 0, 0, 9'h000, 0, 0, ST_IDLE,    0, 0, 9'h000, 0);
    vecs[18] = mk(0, 1, 0, 9'h000, 0, 0, ST_LOAD,    0, 0, 9'h000, 0);
    vecs[19] = mk(0, 0, 1, 9'h111, 0, 0, ST_LOAD,    1, 0, 9'h111, 0);
    vecs[20] = mk(0, 0, 1, 9'h122, 0, 0, ST_LOAD,    1, 1, 9'h122, 0);
    vecs[21] = mk(1, 1, 1, 9'h133, 0, 1, ST_IDLE,    0, 0, 9'h000, 0);
    vecs[22] = mk(0, 1, 0, 9'h000, 0, 0, ST_LOAD,    0, 0, 9'h000, 0);
    vecs[23] = mk(0, 0, 1, 9'h033, 0, 0, ST_LOAD,    1, 0, 9'h033, 0);
    vecs[24] = mk(0, 0, 1, 9'h044, 0, 0, ST_LOAD,    1, 1, 9'h044, 0);
    vecs[25] = mk(0, 0, 1, 9'h055, 0, 0, ST_LOAD,    1, 2, 9'h055, 0);
    vecs[26] = mk(0, 0, 1, 9'h066, 1, 0, ST_COMPUTE, 1, 3, 9'h066, 0);
    vecs[27] = mk(0, 0, 0, 9'h000, 0, 0, ST_COMPUTE, 0, 3, 9'h066, 0);

    #2;
    for (int i = 0; i < 28; i++) apply_vec(i);

`ifdef CHUNK_SEQ_DRAIN_EN
    begin
      int beats;
      int cyc;
      logic stalled;
      logic [LN-1:0] held;
      for (int i = 0; i < 4; i++) exp_q.push_back(bram[i]);
      cdone = 1'b1;
      tick();
      cdone = 1'b0;
      check("drain_state", 32'(fsm_state), 32'(ST_DRAIN));
      check("drain_active", 32'(drain_act), 32'd1);
      check("drain_addr0", 32'(ddr_addr), 32'd0);
      check("drain_cready", 32'(cready), 32'd0);
      beats = 0;
      cyc = 0;
      stalled = 1'b0;
      held = '0;
      while (beats < 4 && cyc < 60) begin
        if (stalled) begin
          check("stall_tvalid", 32'(m_tvalid), 32'd1);
          check("stall_tdata", 32'(m_tdata), 32'(held));
        end
        m_tready = cyc[0];
        #1;
        stalled = m_tvalid && !m_tready;
        held = m_tdata;
        if (m_tvalid && m_tready) begin
          logic [LN-1:0] e;
          e = exp_q.pop_front();
          check($sformatf("beat%0d_data", beats), 32'(m_tdata), 32'(e));
          check($sformatf("beat%0d_tlast", beats), 32'(m_tlast), 32'(beats == 3));
          beats++;
        end
        cyc++;
        tick();
      end
      m_tready = 1'b0;
      if (beats < 4) begin
        n_vec++; n_bad++;
        $display("FAIL drain_timeout: got %0d beats expected 4", beats);
      end
      check("drain_done_pulse", 32'(done), 32'd1);
      check("drain_done_state", 32'(fsm_state), 32'(ST_DONE));
      tick();
      check("post_done_pulse", 32'(done), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
      check("post_state", 32'(fsm_state), 32'(ST_IDLE));
      check("tvalid_seen", 32'(tvalid_cnt > 0), 32'd1);
    end
`else
    cdone = 1'b1;
    tick();
    cdone = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_state", 32'(fsm_state), 32'(ST_DONE));
    check("done_busy", 32'(busy), 32'd1);
    check("done_cready", 32'(cready), 32'd0);
    tick();
    check("post_done_pulse", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_state", 32'(fsm_state), 32'(ST_IDLE));
    cdone = 1'b1;
    tick();
    cdone = 1'b0;
    check("idle_cdone_ignored", 32'(fsm_state), 32'(ST_IDLE));
    check("tvalid_never", 32'(tvalid_cnt), 32'd0);
    check("drain_never", 32'(drain_cnt), 32'd0);
`endif
    check("xfer_cready_overlap", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
